// File: rtl/apb_cmd_master_pkg.sv
// Shared types and widths for the APB command requester.
// Build option: APB_CMD_MASTER_TIMEOUT_EN enables the ACCESS watchdog.
package apb_cmd_master_pkg;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } apb_cmd_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_cmd_master_wdt.sv
// ACCESS-phase wait counter; built only with APB_CMD_MASTER_TIMEOUT_EN.
// hit fires in the wait cycle that brings the count to LIMIT.
module apb_cmd_master_wdt #(
  parameter int LIMIT = 256
) (
  input  logic pclk,
  input  logic prst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  assign hit = inc && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge pclk) begin
    if (prst || clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB4 requester driven by a valid/ready command port.
// Build option: APB_CMD_MASTER_TIMEOUT_EN adds an ACCESS timeout.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int APB_AW         = 32,
  parameter int APB_DW         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                pclk,
  input  logic                prst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [APB_AW-1:0]   cmd_addr,
  input  logic                cmd_write,
  input  logic [APB_DW-1:0]   cmd_wdata,
  input  logic [APB_DW/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [APB_DW-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [APB_AW-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [APB_DW-1:0]   pwdata,
  output logic [APB_DW/8-1:0] pstrb,
  input  logic [APB_DW-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  apb_mst_state_e state_q, state_d;
  apb_cmd_t       hold_q, hold_d;
  apb_rsp_t       rsp_q, rsp_d;
  logic           acc;
  logic           tmo;

  assign acc = cmd_valid & cmd_ready;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  apb_cmd_master_wdt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdt (
    .pclk(pclk),
    .prst(prst),
    .clr (state_q == SETUP),
    .inc (state_q == ACCESS && !pready),
    .hit (tmo)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          hold_d.addr  = cmd_addr;
          hold_d.write = cmd_write;
          // reads put zeros on pwdata/pstrb
          hold_d.wdata = cmd_write ? cmd_wdata : '0;
          hold_d.strb  = cmd_write ? cmd_strb : '0;
          state_d      = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          rsp_d.rdata = hold_q.write ? '0 : prdata;
          rsp_d.err   = pslverr;
          state_d     = RESP;
        end else if (tmo) begin
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      rsp_q     <= '0;
      cmd_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rsp_q     <= rsp_d;
      cmd_ready <= (state_d == IDLE);
      psel      <= (state_d == SETUP) || (state_d == ACCESS);
      penable   <= (state_d == ACCESS);
      rsp_valid <= (state_d == RESP);
    end
  end

  assign paddr     = hold_q.addr;
  assign pwrite    = hold_q.write;
  assign pwdata    = hold_q.wdata;
  assign pstrb     = hold_q.strb;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: directed APB transfers,
// responses popped by an independent monitor.
module tb_apb_cmd_master;
  import apb_cmd_master_pkg::*;

  logic        pclk = 1'b0;
  logic        prst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  logic        echo;
  logic [31:0] prdata_v;
  int          checks;
  int          failures;
  int          cyc;
  apb_rsp_t    exp_q[$];

  assign prdata = echo ? {paddr[15:0], 16'h5A5A} : prdata_v;

  apb_cmd_master #(
    .APB_AW(32),
    .APB_DW(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk(pclk),
    .prst(prst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr),
    .cmd_write(cmd_write),
    .cmd_wdata(cmd_wdata),
    .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .paddr(paddr),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .pwdata(pwdata),
    .pstrb(pstrb),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void push(logic [31:0] rd, logic er);
    apb_rsp_t e;
    e.rdata = rd;
    e.err   = er;
    exp_q.push_back(e);
  endfunction

  always @(negedge pclk) begin
    apb_rsp_t e;
    if (!prst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s,
                       output int hs);
    int n;
    n = 0;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_valid = 1'b1;
    @(negedge pclk);
    while (!cmd_ready && n < 20) begin
      @(negedge pclk);
      n++;
    end
    if (!cmd_ready) chk("issue_timeout", 64'd0, 64'd1);
    @(posedge pclk);
    #1;
    hs = cyc;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, prev;
    checks = 0; failures = 0; cyc = 0;
    prst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0;
    prdata_v = '0; pready = 1'b0; pslverr = 1'b0; echo = 1'b0;

    // reset
    tick(); tick(); tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    prst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // write, zero wait states
    pready = 1'b1; rsp_ready = 1'b1;
    push(32'h0, 1'b0);
    issue(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, hs);
    chk("w_setup_psel", 64'(psel), 64'd1);
    chk("w_setup_penable", 64'(penable), 64'd0);
    chk("w_paddr", 64'(paddr), 64'h10);
    chk("w_pwrite", 64'(pwrite), 64'd1);
    chk("w_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    chk("w_pstrb", 64'(pstrb), 64'hF);
    chk("w_setup_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    chk("w_access_penable", 64'(penable), 64'd1);
    chk("w_access_psel", 64'(psel), 64'd1);
    tick();
    chk("w_rsp_valid_c3", 64'(rsp_valid), 64'd1);
    chk("w_rsp_psel", 64'(psel), 64'd0);
    tick();
    chk("w_idle_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("w_idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // read, 3 wait states
    pready = 1'b0; prdata_v = 32'h1234_5678;
    push(32'h1234_5678, 1'b0);
    issue(32'h0000_0020, 1'b0, 32'hFFFF_FFFF, 4'hF, hs);
    chk("r_pwrite", 64'(pwrite), 64'd0);
    chk("r_pwdata", 64'(pwdata), 64'd0);
    chk("r_setup_pstrb", 64'(pstrb), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r_wait_penable", 64'(penable), 64'd1);
      chk("r_wait_pstrb", 64'(pstrb), 64'd0);
      chk("r_wait_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    tick();
    pready = 1'b1;
    chk("r_c5_penable", 64'(penable), 64'd1);
    tick();
    chk("r_rsp_valid_c6", 64'(rsp_valid), 64'd1);
    tick();

    // slave error with response back-pressure
    rsp_ready = 1'b0; pslverr = 1'b1; prdata_v = 32'hCAFE_0001;
    push(32'hCAFE_0001, 1'b1);
    issue(32'h0000_0030, 1'b0, 32'h0, 4'h0, hs);
    tick();
    tick();
    pslverr = 1'b0; prdata_v = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_rdata", 64'(rsp_rdata), 64'hCAFE_0001);
      chk("bp_rsp_err", 64'(rsp_err), 64'd1);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_done_rsp_valid", 64'(rsp_valid), 64'd0);

    // reset during ACCESS
    pready = 1'b0;
    issue(32'h0000_0044, 1'b1, 32'h1111_2222, 4'hF, hs);
    tick();
    chk("mr_access", 64'(penable), 64'd1);
    prst = 1'b1;
    tick();
    chk("mr_psel", 64'(psel), 64'd0);
    chk("mr_penable", 64'(penable), 64'd0);
    chk("mr_paddr", 64'(paddr), 64'd0);
    chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    prst = 1'b0; pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_rsp", 64'(rsp_valid), 64'd0);
    end
    prdata_v = 32'h0BAD_F00D;
    push(32'h0BAD_F00D, 1'b0);
    issue(32'h0000_0048, 1'b0, 32'h0, 4'h0, hs);
    tick(); tick();
    chk("mr_new_rsp", 64'(rsp_valid), 64'd1);
    tick();

    // timeout
    pready = 1'b0; prdata_v = 32'h5555_5555;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    push(32'h0, 1'b1);
    issue(32'h0000_0050, 1'b0, 32'h0, 4'h0, hs);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_access_psel", 64'(psel), 64'd1);
      chk("to_access_penable", 64'(penable), 64'd1);
    end
    tick();
    chk("to_psel_drop", 64'(psel), 64'd0);
    chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
    tick();
`else
    issue(32'h0000_0050, 1'b0, 32'h0, 4'h0, hs);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("nto_psel", 64'(psel), 64'd1);
      chk("nto_penable", 64'(penable), 64'd1);
      chk("nto_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    prst = 1'b1;
    tick();
    prst = 1'b0;
    tick();
`endif

    // back-to-back
    pready = 1'b1; echo = 1'b1;
    push(32'h0, 1'b0);
    issue(32'h0000_0100, 1'b1, 32'h1111_1111, 4'h3, hs);
    chk("b2b_pstrb", 64'(pstrb), 64'h3);
    prev = hs;
    push(32'h0104_5A5A, 1'b0);
    issue(32'h0000_0104, 1'b0, 32'h0, 4'h0, hs);
    chk("b2b_interval1", 64'(hs - prev), 64'd4);
    prev = hs;
    push(32'h0, 1'b0);
    issue(32'h0000_0108, 1'b1, 32'h2222_2222, 4'h0, hs);
    chk("b2b_interval2", 64'(hs - prev), 64'd4);
    chk("b2b_zero_strb", 64'(pstrb), 64'h0);
    prev = hs;
    push(32'h010C_5A5A, 1'b0);
    issue(32'h0000_010C, 1'b0, 32'h0, 4'h0, hs);
    chk("b2b_interval3", 64'(hs - prev), 64'd4);
    for (int i = 0; i < 5; i++) tick();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
